pwr_seq_ctrl: RTL and testbench



---
 rtl/pwr_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pwr_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pwr_seq_ctrl.sv
// rtl/pwr_seq_ctrl.sv - power-domain sequencer for one switchable logic domain
//
// Watches domain activity and, after IDLE_CYCLES idle cycles, walks the domain
// through clock gating, isolation, (optional) retention save and power-switch
// off. A wake request reverses the sequence after the power-switch handshake.
//
// Optional feature macro: RETENTION_EN (adds the SAVE and RESTORE states and
// drives ret_save_o / ret_restore_o; when undefined both strobes are tied 0).
//
// Ports:
//   clk_i          always-on clock
//   reset_i        synchronous active-high reset
//   busy_i         domain activity, 1 = keep powered and clocked
//   wake_req_i     external wake request (level)
//   pwr_ack_i      power-switch status, 1 = rail good
//   clk_en_o       domain clock-gate enable
//   iso_en_o       isolation clamp enable
//   ret_save_o     retention save strobe (one cycle)
//   ret_restore_o  retention restore strobe (one cycle)
//   pwr_on_o       power-switch request
//   sleeping_o     domain fully off (OFF with pwr_ack_i=0 observed)
//   state_o        current state encoding

module pwr_seq_ctrl #(
   parameter int IDLE_CYCLES   = 16,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       busy_i,
   input  logic       wake_req_i,
   input  logic       pwr_ack_i,
   output logic       clk_en_o,
   output logic       iso_en_o,
   output logic       ret_save_o,
   output logic       ret_restore_o,
   output logic       pwr_on_o,
   output logic       sleeping_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      ST_ACTIVE  = 3'd0,
      ST_GATE    = 3'd1,
      ST_ISO     = 3'd2,
      ST_SAVE    = 3'd3,
      ST_OFF     = 3'd4,
      ST_ON      = 3'd5,
      ST_RESTORE = 3'd6,
      ST_UNISO   = 3'd7
   } state_e;

   localparam int CNT_MAX = (IDLE_CYCLES > SETTLE_CYCLES) ? IDLE_CYCLES : SETTLE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] IDLE_LAST   = CW'(IDLE_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] idle_cnt_q, idle_cnt_d;
   logic [CW-1:0] settle_cnt_q, settle_cnt_d;
   logic          sleeping_q, sleeping_d;
   logic          clk_en_q, iso_en_q, pwr_on_q, ret_save_q, ret_restore_q;
   logic          activity;
   logic          settle_done;

   assign activity    = busy_i | wake_req_i;
   assign settle_done = (settle_cnt_q == SETTLE_LAST);

   always_comb begin
      state_d    = state_q;
      idle_cnt_d = '0;
      case (state_q)
         ST_ACTIVE: begin
            // The edge sampling the last required idle cycle enters GATE;
            // the counter saturates rather than wrapping.
            if (activity)                    idle_cnt_d = '0;
            else if (idle_cnt_q >= IDLE_LAST) state_d    = ST_GATE;
            else                             idle_cnt_d = idle_cnt_q + 1'b1;
         end
         ST_GATE: begin
            if (activity)         state_d = ST_ACTIVE;
            else if (settle_done) state_d = ST_ISO;
         end
         ST_ISO: begin
            // Abort goes through UNISO only: nothing was saved yet.
            if (activity)         state_d = ST_UNISO;
`ifdef RETENTION_EN
            else if (settle_done) state_d = ST_SAVE;
`else
            else if (settle_done) state_d = ST_OFF;
`endif
         end
`ifdef RETENTION_EN
         ST_SAVE:    state_d = ST_OFF;
         ST_RESTORE: state_d = ST_UNISO;
`endif
         ST_OFF: begin
            // Hold off a wake until the rail is seen low so the switch
            // never gets a short off pulse.
            if (activity && !pwr_ack_i) state_d = ST_ON;
         end
         ST_ON: begin
`ifdef RETENTION_EN
            if (pwr_ack_i) state_d = ST_RESTORE;
`else
            if (pwr_ack_i) state_d = ST_UNISO;
`endif
         end
         ST_UNISO: begin
            if (settle_done) state_d = ST_ACTIVE;
         end
         default: state_d = ST_ACTIVE;
      endcase

      // Settle counter restarts on every state entry.
      if (state_d != state_q)  settle_cnt_d = '0;
      else if (settle_done)    settle_cnt_d = settle_cnt_q;
      else                     settle_cnt_d = settle_cnt_q + 1'b1;

      sleeping_d = (state_q == ST_OFF) && (state_d == ST_OFF) && !pwr_ack_i;
   end

   // Outputs are decoded from the next state so they change on the same
   // edge as state_q and come straight from flops.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= ST_ACTIVE;
         idle_cnt_q    <= '0;
         settle_cnt_q  <= '0;
         sleeping_q    <= 1'b0;
         clk_en_q      <= 1'b1;
         iso_en_q      <= 1'b0;
         pwr_on_q      <= 1'b1;
         ret_save_q    <= 1'b0;
         ret_restore_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idle_cnt_q    <= idle_cnt_d;
         settle_cnt_q  <= settle_cnt_d;
         sleeping_q    <= sleeping_d;
         clk_en_q      <= (state_d == ST_ACTIVE);
         iso_en_q      <= (state_d == ST_ISO) || (state_d == ST_SAVE) || (state_d == ST_OFF) ||
                          (state_d == ST_ON)  || (state_d == ST_RESTORE);
         pwr_on_q      <= (state_d != ST_OFF);
         ret_save_q    <= (state_d == ST_SAVE);
         ret_restore_q <= (state_d == ST_RESTORE);
      end
   end

   assign clk_en_o   = clk_en_q;
   assign iso_en_o   = iso_en_q;
   assign pwr_on_o   = pwr_on_q;
   assign sleeping_o = sleeping_q;
   assign state_o    = state_q;
`ifdef RETENTION_EN
   assign ret_save_o    = ret_save_q;
   assign ret_restore_o = ret_restore_q;
`else
   assign ret_save_o    = 1'b0;
   assign ret_restore_o = 1'b0;
   logic unused_ret;
   assign unused_ret = ret_save_q ^ ret_restore_q;
`endif

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb/tb_pwr_seq_ctrl.sv - directed vector bench for pwr_seq_ctrl (default parameters)

module tb_pwr_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset, busy, wake_req, pwr_ack;
   logic       clk_en, iso_en, ret_save, ret_restore, pwr_on, sleeping;
   logic [2:0] state;

   always #5 clk = ~clk;

`ifdef RETENTION_EN
   localparam bit RET = 1'b1;
`else
   localparam bit RET = 1'b0;
`endif

   pwr_seq_ctrl dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .busy_i       (busy),
      .wake_req_i   (wake_req),
      .pwr_ack_i    (pwr_ack),
      .clk_en_o     (clk_en),
      .iso_en_o     (iso_en),
      .ret_save_o   (ret_save),
      .ret_restore_o(ret_restore),
      .pwr_on_o     (pwr_on),
      .sleeping_o   (sleeping),
      .state_o      (state)
   );

   typedef struct {
      logic       rst;
      logic       busy;
      logic       wake;
      logic       ack;
      logic [2:0] st;
      logic       slp;
      string      tag;
   } vec_t;

   vec_t vq[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic add(input int n, input logic rst, input logic b, input logic w, input logic a,
                      input logic [2:0] st, input logic slp, input string tag);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.rst = rst; v.busy = b; v.wake = w; v.ack = a; v.st = st; v.slp = slp; v.tag = tag;
         vq.push_back(v);
      end
   endtask

   // From ACTIVE with a cleared idle counter down to OFF, rail still good.
   task automatic add_down(input string tag);
      add(15, 0, 0, 0, 1, 3'd0, 0, tag);
      add(1,  0, 0, 0, 1, 3'd1, 0, tag);
      add(3,  0, 0, 0, 1, 3'd1, 0, tag);
      add(1,  0, 0, 0, 1, 3'd2, 0, tag);
      add(3,  0, 0, 0, 1, 3'd2, 0, tag);
      if (RET) add(1, 0, 0, 0, 1, 3'd3, 0, tag);
      add(1,  0, 0, 0, 1, 3'd4, 0, tag);
   endtask

   // From ON, rail comes good and the domain returns to ACTIVE.
   task automatic add_up(input string tag);
      add(1, 0, 0, 0, 1, RET ? 3'd6 : 3'd7, 0, tag);
      if (RET) add(1, 0, 0, 0, 1, 3'd7, 0, tag);
      add(3, 0, 0, 0, 1, 3'd7, 0, tag);
      add(1, 0, 0, 0, 1, 3'd0, 0, tag);
   endtask

   // Output values per state, from the state/output table.
   function automatic logic [8:0] exp_outs(input logic [2:0] st, input logic slp);
      logic ce, iso, on, sv, rs;
      ce  = (st == 3'd0);
      iso = (st == 3'd2) || (st == 3'd3) || (st == 3'd4) || (st == 3'd5) || (st == 3'd6);
      on  = (st != 3'd4);
      sv  = RET && (st == 3'd3);
      rs  = RET && (st == 3'd6);
      return {st, ce, iso, on, sv, rs, slp};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      logic [8:0] act, exp;
      int cnt, n_restore;

      reset = 1'b1; busy = 1'b0; wake_req = 1'b0; pwr_ack = 1'b1;

      add(2, 1, 0, 0, 1, 3'd0, 0, "reset");
      add(5, 0, 1, 0, 1, 3'd0, 0, "busy");
      add_down("down");
      add(1, 0, 0, 0, 1, 3'd4, 0, "off_ack_hi");
      add(2, 0, 0, 0, 0, 3'd4, 1, "off_sleep");
      add(1, 0, 0, 1, 0, 3'd5, 0, "wake");
      add(2, 0, 0, 0, 0, 3'd5, 0, "on_wait");
      add_up("up");
      // abort in the second GATE cycle
      add(15, 0, 0, 0, 1, 3'd0, 0, "idle");
      add(1,  0, 0, 0, 1, 3'd1, 0, "gate");
      add(1,  0, 0, 0, 1, 3'd1, 0, "gate1");
      add(1,  0, 1, 0, 1, 3'd0, 0, "gate_abort");
      // abort in ISO, busy ignored during UNISO
      add(15, 0, 0, 0, 1, 3'd0, 0, "idle2");
      add(1,  0, 0, 0, 1, 3'd1, 0, "gate2");
      add(3,  0, 0, 0, 1, 3'd1, 0, "gate2");
      add(1,  0, 0, 0, 1, 3'd2, 0, "iso2");
      add(1,  0, 1, 0, 1, 3'd7, 0, "iso_abort");
      add(3,  0, 1, 0, 1, 3'd7, 0, "uniso_busy");
      add(1,  0, 0, 0, 1, 3'd0, 0, "uniso_done");
      // wake while rail still good is held until pwr_ack=0
      add_down("down2");
      add(2, 0, 0, 1, 1, 3'd4, 0, "wake_ack_hi");
      add(1, 0, 0, 1, 0, 3'd5, 0, "wake_ack_lo");
      add(1, 0, 0, 0, 0, 3'd5, 0, "on_wait2");
      add_up("up2");
      // reset in ISO (SAVE with retention)
      add(15, 0, 0, 0, 1, 3'd0, 0, "idle3");
      add(1,  0, 0, 0, 1, 3'd1, 0, "gate3");
      add(3,  0, 0, 0, 1, 3'd1, 0, "gate3");
      add(1,  0, 0, 0, 1, 3'd2, 0, "iso3");
      add(3,  0, 0, 0, 1, 3'd2, 0, "iso3");
      if (RET) add(1, 0, 0, 0, 1, 3'd3, 0, "save3");
      add(1,  1, 0, 0, 1, 3'd0, 0, "reset_mid_down");
      // reset in ON
      add_down("down4");
      add(1, 0, 0, 0, 0, 3'd4, 1, "off4");
      add(1, 0, 0, 1, 0, 3'd5, 0, "wake4");
      add(1, 1, 0, 0, 0, 3'd0, 0, "reset_on");
      add(1, 0, 1, 0, 1, 3'd0, 0, "after_reset");

      foreach (vq[i]) begin
         reset = vq[i].rst; busy = vq[i].busy; wake_req = vq[i].wake; pwr_ack = vq[i].ack;
         @(posedge clk); #1;
         act = {state, clk_en, iso_en, pwr_on, ret_save, ret_restore, sleeping};
         exp = exp_outs(vq[i].st, vq[i].slp);
         n_vec++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL vec %0d %s: got st=%0d ce/iso/on/sv/rs/slp=%b expected st=%0d %b",
                     i, vq[i].tag, act[8:6], act[5:0], exp[8:6], exp[5:0]);
         end
      end

      // Interrupted idle run: the counter must restart from zero.
      reset = 1'b0; busy = 1'b0; wake_req = 1'b0; pwr_ack = 1'b1;
      repeat (15) @(posedge clk);
      #1 busy = 1'b1;
      @(posedge clk); #1 busy = 1'b0;
      cnt = 0;
      while (state !== 3'd1 && cnt < 40) begin @(posedge clk); #1; cnt++; end
      check("idle_restart", cnt, 16);

      cnt = 0;
      while (state !== 3'd4 && cnt < 40) begin @(posedge clk); #1; cnt++; end
      check("down_latency", cnt, RET ? 9 : 8);
      check("off_pwr_on", pwr_on, 0);

      pwr_ack = 1'b0;
      @(posedge clk); #1;
      check("sleeping_set", sleeping, 1);
      wake_req = 1'b1;
      @(posedge clk); #1 wake_req = 1'b0;
      check("wake_to_on", state, 5);
      pwr_ack = 1'b1;
      cnt = 0; n_restore = 0;
      while (state !== 3'd0 && cnt < 40) begin
         @(posedge clk); #1; cnt++;
         if (ret_restore === 1'b1) n_restore++;
      end
      check("up_latency", cnt, RET ? 6 : 5);
      check("restore_pulses", n_restore, RET ? 1 : 0);
      check("active_outs", {clk_en, iso_en, pwr_on}, 3'b101);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
